// File: rtl/imem_line_responder.sv
// Single-line instruction buffer for the fetch stage: hits return the buffered word,
// misses stall fetch and refill the whole line one word at a time over req/gnt/rvalid.
module imem_line_responder #(
   parameter int                size       = 32,
   parameter int                LINE_WORDS = 4,
   parameter logic [size-1:0]   NOP_INSTR  = 32'h00000013
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [size-1:0] pc_i,
   input  logic            invalidate_i,
   output logic [size-1:0] instruction_o,
   output logic            stall_o,
   output logic            mem_req_o,
   output logic [size-1:0] mem_addr_o,
   input  logic            mem_gnt_i,
   input  logic            mem_rvalid_i,
   input  logic [size-1:0] mem_rdata_i
);

   localparam int OFF   = $clog2(LINE_WORDS);
   localparam int TAG_W = size - 2 - OFF;
   localparam logic [OFF-1:0] LAST = OFF'(LINE_WORDS - 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t           state_q, state_d;
   logic             line_valid;
   logic             discard;
   logic [OFF-1:0]   k;
   logic [TAG_W-1:0] line_tag;
   logic [TAG_W-1:0] fill_tag;
   logic [size-1:0]  line_data [LINE_WORDS];

   logic [TAG_W-1:0] pc_tag;
   logic [OFF-1:0]   pc_word;
   logic             hit;
   logic             last_beat;

   assign pc_tag    = pc_i[size-1:2+OFF];
   assign pc_word   = pc_i[OFF+1:2];
   // line_valid is held low for the whole fill, so a hit can only come from a completed line
   assign hit       = line_valid && (pc_tag == line_tag);
   assign last_beat = (state_q == WAIT) && mem_rvalid_i && (k == LAST);

   assign instruction_o = hit ? line_data[pc_word] : NOP_INSTR;
   assign stall_o       = !hit;

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      mem_req_o  = 1'b0;
      mem_addr_o = '0;
      case (state_q)
         IDLE: if (!hit) state_d = REQ;
         REQ: begin
            mem_req_o  = 1'b1;
            mem_addr_o = {fill_tag, k, 2'b00};
            if (mem_gnt_i) state_d = WAIT;
         end
         WAIT: begin
            if (mem_rvalid_i) state_d = (k == LAST) ? IDLE : REQ;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         line_valid <= 1'b0;
         discard    <= 1'b0;
         k          <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (invalidate_i) line_valid <= 1'b0;
               if (!hit) begin
                  line_valid <= 1'b0;
                  discard    <= 1'b0;
                  k          <= '0;
               end
            end
            REQ: begin
               if (invalidate_i) discard <= 1'b1;
            end
            WAIT: begin
               if (invalidate_i) discard <= 1'b1;
               if (mem_rvalid_i) begin
                  // an invalidate landing on the final beat must still kill the line
                  if (k == LAST) line_valid <= !(discard || invalidate_i);
                  else           k          <= k + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Line contents and tags carry no reset; line_valid guards every use.
   always_ff @(posedge clk) begin
      if (state_q == IDLE && !hit) fill_tag <= pc_tag;
      if (state_q == WAIT && mem_rvalid_i) line_data[k] <= mem_rdata_i;
      if (last_beat) line_tag <= fill_tag;
   end

endmodule

// File: tb/tb_imem_line_responder.sv
// Bench for imem_line_responder: a configurable-latency memory model checks every request
// address against a queue of expected fetches; scenario tasks check stall timing and data.
module tb_imem_line_responder;

   localparam logic [31:0] NOP = 32'h00000013;
   localparam logic [31:0] XM  = 32'hA5A50000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] pc_i = '0;
   logic        invalidate_i = 1'b0;
   logic [31:0] instruction_o;
   logic        stall_o;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_gnt_i = 1'b0;
   logic        mem_rvalid_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_q[$];
   int gnt_delay = 0;
   int rv_delay  = 1;

   imem_line_responder dut (
      .clk(clk), .reset(reset), .pc_i(pc_i), .invalidate_i(invalidate_i),
      .instruction_o(instruction_o), .stall_o(stall_o),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk = ~clk;

   // Memory model: decides gnt/rvalid on the falling edge for the next rising edge.
   task automatic mem_model();
      int gnt_cnt = 0;
      int rv_cnt = 0;
      bit pending = 1'b0;
      logic [31:0] pend_addr = '0;
      forever begin
         @(negedge clk);
         mem_gnt_i    = 1'b0;
         mem_rvalid_i = 1'b0;
         if (reset) begin
            pending = 1'b0;
            gnt_cnt = 0;
         end else begin
            if (pending) begin
               if (rv_cnt == 0) begin
                  mem_rvalid_i = 1'b1;
                  mem_rdata_i  = pend_addr ^ XM;
                  pending      = 1'b0;
               end else rv_cnt--;
            end
            if (mem_req_o) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL req_unexpected: got addr %h, none expected", mem_addr_o);
               end else if (mem_addr_o !== exp_q[0]) begin
                  errors++;
                  $display("FAIL req_addr: got %h expected %h", mem_addr_o, exp_q[0]);
               end
               if (gnt_cnt == gnt_delay) begin
                  mem_gnt_i = 1'b1;
                  gnt_cnt   = 0;
                  pend_addr = mem_addr_o;
                  pending   = 1'b1;
                  rv_cnt    = rv_delay - 1;
                  if (exp_q.size() != 0) void'(exp_q.pop_front());
               end else gnt_cnt++;
            end
         end
      end
   endtask

   task automatic push_line(input logic [31:0] base);
      for (int w = 0; w < 4; w++) exp_q.push_back(base + 32'(4 * w));
   endtask

   task automatic set_pc(input logic [31:0] a);
      pc_i = a;
      #1;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_unstall(output int cyc);
      cyc = 0;
      while (stall_o === 1'b1 && cyc < 200) begin
         next_cycle();
         cyc++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      pc_i  = 32'h100;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL reset_stall: got %b expected 1", stall_o); end
      checks++; if (instruction_o !== NOP) begin errors++; $display("FAIL reset_instr: got %h expected %h", instruction_o, NOP); end
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", mem_req_o); end
      checks++; if (mem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", mem_addr_o); end
   endtask

   task automatic test_cold_start();
      int cyc;
      push_line(32'h100);
      wait_unstall(cyc);
      checks++; if (cyc != 9) begin errors++; $display("FAIL cold_latency: got %0d expected 9", cyc); end
      checks++; if (instruction_o !== 32'hA5A50100) begin errors++; $display("FAIL cold_instr: got %h expected a5a50100", instruction_o); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL cold_reqs: got %0d left expected 0", exp_q.size()); end
   endtask

   task automatic test_hit_sweep();
      int cyc;
      for (int i = 0; i < 4; i++) begin
         set_pc(32'h100 + 32'(4 * i));
         checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL hit_stall[%0d]: got %b expected 0", i, stall_o); end
         checks++; if (instruction_o !== ((32'h100 + 32'(4 * i)) ^ XM)) begin
            errors++; $display("FAIL hit_instr[%0d]: got %h expected %h", i, instruction_o, (32'h100 + 32'(4 * i)) ^ XM); end
         checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL hit_req[%0d]: got %b expected 0", i, mem_req_o); end
         next_cycle();
      end
      set_pc(32'h10F);
      checks++; if (instruction_o !== (32'h10C ^ XM)) begin errors++; $display("FAIL hit_lowbits: got %h expected %h", instruction_o, 32'h10C ^ XM); end
      push_line(32'h110);
      set_pc(32'h110);
      checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL next_line_miss: got %b expected 1", stall_o); end
      wait_unstall(cyc);
      checks++; if (cyc != 9) begin errors++; $display("FAIL next_line_latency: got %0d expected 9", cyc); end
      checks++; if (instruction_o !== (32'h110 ^ XM)) begin errors++; $display("FAIL next_line_instr: got %h expected %h", instruction_o, 32'h110 ^ XM); end
   endtask

   task automatic test_wait_states();
      int cyc;
      gnt_delay = 3;
      rv_delay  = 2;
      push_line(32'h300);
      set_pc(32'h308);
      wait_unstall(cyc);
      checks++; if (cyc != 25) begin errors++; $display("FAIL ws_latency: got %0d expected 25", cyc); end
      checks++; if (instruction_o !== (32'h308 ^ XM)) begin errors++; $display("FAIL ws_instr: got %h expected %h", instruction_o, 32'h308 ^ XM); end
      gnt_delay = 0;
      rv_delay  = 1;
   endtask

   task automatic test_redirect();
      int cyc;
      push_line(32'h100);
      push_line(32'h200);
      set_pc(32'h100);
      repeat (5) next_cycle();
      set_pc(32'h204);
      wait_unstall(cyc);
      checks++; if (cyc != 13) begin errors++; $display("FAIL redirect_latency: got %0d expected 13", cyc); end
      checks++; if (instruction_o !== (32'h204 ^ XM)) begin errors++; $display("FAIL redirect_instr: got %h expected %h", instruction_o, 32'h204 ^ XM); end
      push_line(32'h100);
      set_pc(32'h104);
      checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL redirect_old_miss: got %b expected 1", stall_o); end
      wait_unstall(cyc);
      checks++; if (cyc != 9) begin errors++; $display("FAIL refill_latency: got %0d expected 9", cyc); end
   endtask

   task automatic test_invalidate();
      int cyc;
      // during WAIT of word 0
      push_line(32'h400);
      push_line(32'h400);
      set_pc(32'h400);
      repeat (2) next_cycle();
      invalidate_i = 1'b1;
      next_cycle();
      invalidate_i = 1'b0;
      wait_unstall(cyc);
      checks++; if (cyc != 15) begin errors++; $display("FAIL inv_wait_latency: got %0d expected 15", cyc); end
      checks++; if (instruction_o !== (32'h400 ^ XM)) begin errors++; $display("FAIL inv_wait_instr: got %h expected %h", instruction_o, 32'h400 ^ XM); end
      // on the cycle of the final rvalid
      push_line(32'h500);
      push_line(32'h500);
      set_pc(32'h500);
      repeat (8) next_cycle();
      invalidate_i = 1'b1;
      next_cycle();
      invalidate_i = 1'b0;
      #1;
      checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL inv_last_stall: got %b expected 1", stall_o); end
      wait_unstall(cyc);
      checks++; if (cyc != 9) begin errors++; $display("FAIL inv_last_latency: got %0d expected 9", cyc); end
      // in IDLE on a hit
      push_line(32'h500);
      invalidate_i = 1'b1;
      #1;
      checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL inv_idle_same: got %b expected 0", stall_o); end
      next_cycle();
      invalidate_i = 1'b0;
      #1;
      checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL inv_idle_next: got %b expected 1", stall_o); end
      wait_unstall(cyc);
      checks++; if (cyc != 9) begin errors++; $display("FAIL inv_idle_latency: got %0d expected 9", cyc); end
   endtask

   task automatic test_reset_mid_fill();
      int cyc;
      exp_q.push_back(32'h600);
      exp_q.push_back(32'h604);
      set_pc(32'h600);
      repeat (4) next_cycle();
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      #1;
      checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rst_fill_req: got %b expected 0", mem_req_o); end
      checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL rst_fill_stall: got %b expected 1", stall_o); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rst_fill_reqs: got %0d left expected 0", exp_q.size()); end
      push_line(32'h600);
      wait_unstall(cyc);
      checks++; if (cyc != 9) begin errors++; $display("FAIL rst_fill_latency: got %0d expected 9", cyc); end
      checks++; if (instruction_o !== (32'h600 ^ XM)) begin errors++; $display("FAIL rst_fill_instr: got %h expected %h", instruction_o, 32'h600 ^ XM); end
   endtask

   initial begin
      fork
         mem_model();
      join_none
      test_reset();
      test_cold_start();
      test_hit_sweep();
      test_wait_states();
      test_redirect();
      test_invalidate();
      test_reset_mid_fill();
      repeat (3) next_cycle();
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL final_reqs: got %0d left expected 0", exp_q.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
